// File: rtl/pong_pkg.sv
// Shared Pong constants, paddle FSM state encoding and detent helper.
package pong_pkg;

  localparam int unsigned SCREEN_H  = 480;
  localparam int unsigned PADDLE_H  = 64;
  localparam int unsigned Y_W       = 10;
  localparam int unsigned POS_W     = 12;
  localparam int unsigned ACC_W     = 5;
  localparam int unsigned ACC_LIMIT = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SLOW = 2'd1,
    ST_FAST = 2'd2
  } paddle_state_e;

  // Net detent contribution of one cycle: +1 down, -1 up, 0 if none or both.
  function automatic logic signed [ACC_W-1:0] pulse_contrib(input logic i_down_pulse,
                                                            input logic i_up_pulse);
    logic signed [ACC_W-1:0] v;
    v = '0;
    if (i_down_pulse && !i_up_pulse) v = ACC_W'(1);
    else if (i_up_pulse && !i_down_pulse) v = -(ACC_W'(1));
    return v;
  endfunction

endpackage

// File: rtl/detent_accum.sv
// Saturating signed detent accumulator, reloaded once per frame.
module detent_accum
  import pong_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_inc,
  input  logic                    i_dec,
  input  logic                    i_reload,
  output logic signed [ACC_W-1:0] o_acc
);

  localparam logic signed [ACC_W-1:0] ACC_MAX_V = ACC_W'(ACC_LIMIT);
  localparam logic signed [ACC_W-1:0] ACC_MIN_V = -ACC_MAX_V;

  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_contrib;
  logic signed [ACC_W-1:0] w_acc_nxt;

  assign w_contrib = pulse_contrib(i_inc, i_dec);

  // A pulse in the reload cycle seeds the next frame instead of the current one.
  always_comb begin
    w_acc_nxt = r_acc;
    if (i_reload) begin
      w_acc_nxt = w_contrib;
    end else if (i_inc && !i_dec && (r_acc != ACC_MAX_V)) begin
      w_acc_nxt = r_acc + ACC_W'(1);
    end else if (i_dec && !i_inc && (r_acc != ACC_MIN_V)) begin
      w_acc_nxt = r_acc - ACC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_acc <= '0;
    else      r_acc <= w_acc_nxt;
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/paddle_ctrl.sv
// Paddle position controller: per-frame detent accumulation with slow/fast step FSM.
module paddle_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned Y_MIN       = 0,
  parameter int unsigned Y_MAX       = SCREEN_H - PADDLE_H,
  parameter int unsigned Y_RESET     = 208,
  parameter int unsigned STEP_SLOW   = 4,
  parameter int unsigned STEP_FAST   = 12,
  parameter int unsigned FAST_FRAMES = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rot_l_oneshot,
  input  logic           rot_r_oneshot,
  input  logic           frame_tick,
  output logic [Y_W-1:0] paddle_y,
  output logic           at_top,
  output logic           at_bottom,
  output logic           move_valid
);

  localparam int unsigned RUN_W = (FAST_FRAMES > 1) ? $clog2(FAST_FRAMES + 1) : 1;
  localparam logic [RUN_W-1:0]        RUN_FAST    = RUN_W'(FAST_FRAMES);
  localparam logic [RUN_W-1:0]        RUN_ONE     = RUN_W'(1);
  localparam logic [Y_W-1:0]          Y_MIN_V     = Y_W'(Y_MIN);
  localparam logic [Y_W-1:0]          Y_MAX_V     = Y_W'(Y_MAX);
  localparam logic [Y_W-1:0]          Y_RESET_V   = Y_W'(Y_RESET);
  localparam logic signed [POS_W-1:0] Y_MIN_S     = POS_W'(Y_MIN);
  localparam logic signed [POS_W-1:0] Y_MAX_S     = POS_W'(Y_MAX);
  localparam logic signed [POS_W-1:0] STEP_SLOW_S = POS_W'(STEP_SLOW);
  localparam logic signed [POS_W-1:0] STEP_FAST_S = POS_W'(STEP_FAST);

  paddle_state_e           r_state, w_state_nxt;
  logic [RUN_W-1:0]        r_run, w_run_nxt, w_run_inc;
  logic                    r_dir_down, w_dir_down_nxt;
  logic signed [ACC_W-1:0] w_acc;
  logic                    w_acc_nz, w_acc_down, w_same_dir;
  logic signed [POS_W-1:0] w_acc_ext, w_step, w_delta, w_sum;
  logic [Y_W-1:0]          w_y_nxt;
  logic [Y_W-1:0]          r_paddle_y;
  logic                    r_at_top, r_at_bottom, r_move_valid;

  detent_accum u_accum (
    .clk      (clk),
    .rst      (rst),
    .i_inc    (rot_r_oneshot),
    .i_dec    (rot_l_oneshot),
    .i_reload (frame_tick),
    .o_acc    (w_acc)
  );

  assign w_acc_nz   = (w_acc != '0);
  assign w_acc_down = ~w_acc[ACC_W-1];
  assign w_same_dir = (w_acc_down == r_dir_down);
  assign w_run_inc  = r_run + RUN_ONE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_run      <= '0;
      r_dir_down <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_run      <= w_run_nxt;
      r_dir_down <= w_dir_down_nxt;
    end
  end

  // Speed FSM: advances only on frame_tick, judged on the finished frame's accumulator.
  always_comb begin
    w_state_nxt    = r_state;
    w_run_nxt      = r_run;
    w_dir_down_nxt = r_dir_down;
    if (frame_tick) begin
      if (!w_acc_nz) begin
        w_state_nxt = ST_IDLE;
        w_run_nxt   = '0;
      end else begin
        case (r_state)
          ST_SLOW: begin
            if (w_same_dir) begin
              if (w_run_inc >= RUN_FAST) begin
                w_state_nxt = ST_FAST;
                w_run_nxt   = RUN_FAST;
              end else begin
                w_run_nxt = w_run_inc;
              end
            end else begin
              w_run_nxt      = RUN_ONE;
              w_dir_down_nxt = w_acc_down;
            end
          end
          ST_FAST: begin
            if (w_same_dir) begin
              w_run_nxt = RUN_FAST;
            end else begin
              w_state_nxt    = ST_SLOW;
              w_run_nxt      = RUN_ONE;
              w_dir_down_nxt = w_acc_down;
            end
          end
          default: begin
            w_state_nxt    = ST_SLOW;
            w_run_nxt      = RUN_ONE;
            w_dir_down_nxt = w_acc_down;
          end
        endcase
      end
    end
  end

  assign w_acc_ext = {{(POS_W - ACC_W){w_acc[ACC_W-1]}}, w_acc};
  assign w_step    = (r_state == ST_FAST) ? STEP_FAST_S : STEP_SLOW_S;
  assign w_delta   = w_acc_ext * w_step;
  assign w_sum     = $signed({{(POS_W - Y_W){1'b0}}, r_paddle_y}) + w_delta;

  // Signed sum so upward moves past the top clamp instead of wrapping.
  always_comb begin
    w_y_nxt = r_paddle_y;
    if (frame_tick) begin
      if (w_sum < Y_MIN_S)      w_y_nxt = Y_MIN_V;
      else if (w_sum > Y_MAX_S) w_y_nxt = Y_MAX_V;
      else                      w_y_nxt = w_sum[Y_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_paddle_y   <= Y_RESET_V;
      r_at_top     <= (Y_RESET_V == Y_MIN_V);
      r_at_bottom  <= (Y_RESET_V == Y_MAX_V);
      r_move_valid <= 1'b0;
    end else begin
      r_paddle_y   <= w_y_nxt;
      r_at_top     <= (w_y_nxt == Y_MIN_V);
      r_at_bottom  <= (w_y_nxt == Y_MAX_V);
      r_move_valid <= (w_y_nxt != r_paddle_y);
    end
  end

  assign paddle_y   = r_paddle_y;
  assign at_top     = r_at_top;
  assign at_bottom  = r_at_bottom;
  assign move_valid = r_move_valid;

endmodule

// File: doc/paddle_ctrl.md
PADDLE_CTRL -- requirements
Module: paddle_ctrl

Interface
REQ-001 Parameter Y_MIN, default 0: topmost legal paddle_y.
REQ-002 Parameter Y_MAX, default 416: bottommost legal paddle_y (480 - 64).
REQ-003 Parameter Y_RESET, default 208: paddle_y after reset.
REQ-004 Parameter STEP_SLOW, default 4: pixels per detent in IDLE/SLOW.
REQ-005 Parameter STEP_FAST, default 12: pixels per detent in FAST.
REQ-006 Parameter FAST_FRAMES, default 3: consecutive same-direction active frames needed to enter FAST.
REQ-007 Port clk  input  1  single system clock; all logic on its rising edge.
REQ-008 Port rst  input  1  asynchronous, active-low reset.
REQ-009 Port rot_l_oneshot  input  1  one-cycle pulse per left detent (move up).
REQ-010 Port rot_r_oneshot  input  1  one-cycle pulse per right detent (move down).
REQ-011 Port frame_tick  input  1  one-cycle pulse once per video frame.
REQ-012 Port paddle_y  output  10  registered paddle top-edge row.
REQ-013 Port at_top  output  1  registered; high when paddle_y == Y_MIN.
REQ-014 Port at_bottom  output  1  registered; high when paddle_y == Y_MAX.
REQ-015 Port move_valid  output  1  one-cycle pulse when paddle_y changed.

Function
REQ-016 Signed 5-bit accumulator acc: +1 per rot_r_oneshot, -1 per rot_l_oneshot; saturates at +15/-15.
REQ-017 rot_l_oneshot and rot_r_oneshot high in the same cycle leave acc unchanged.
REQ-018 On frame_tick, acc reloads with that cycle's pulse contribution (0, +1 or -1); that pulse counts toward the next frame, never the current one.
REQ-019 On frame_tick, delta = acc_before_tick * step, where step = STEP_FAST if state is FAST, else STEP_SLOW (state before transition).
REQ-020 New position = paddle_y + delta, computed in 12-bit signed, clamped to [Y_MIN, Y_MAX]; registered one cycle after frame_tick (latency 1).
REQ-021 move_valid pulses in the same cycle paddle_y takes its new value, only if the value differs from the old one; clamped no-change gives no pulse.
REQ-022 at_top/at_bottom update in the same cycle as paddle_y.
REQ-023 States IDLE, SLOW, FAST; transitions evaluated only on frame_tick.
REQ-024 Any state, acc == 0 -> IDLE; run counter cleared.
REQ-025 IDLE, acc != 0 -> SLOW; run counter = 1; direction = sign(acc).
REQ-026 SLOW, acc != 0, same direction -> run counter +1; reaching FAST_FRAMES -> FAST.
REQ-027 SLOW or FAST, acc != 0, opposite direction -> SLOW; run counter = 1; direction updated.
REQ-028 FAST, acc != 0, same direction -> stay FAST; run counter saturates.
REQ-029 Without frame_tick, paddle_y never changes regardless of pulse activity.

Reset
REQ-030 rst low asynchronously forces paddle_y = Y_RESET, acc = 0, state IDLE, run counter 0, direction up, move_valid 0, at_top/at_bottom per Y_RESET.
REQ-031 Reset asserted mid-frame discards accumulated detents; first frame_tick after release applies only post-release pulses.

Structure
REQ-032 State encoding, SCREEN_H (480) and PADDLE_H (64) constants live in shared package pong_pkg.
REQ-033 Accumulator and saturation are one sub-module, detent_accum; FSM, multiply and clamp stay in paddle_ctrl.

Verification
REQ-034 Reset, 3 rot_r pulses, frame_tick -> paddle_y 208->220 next cycle, move_valid one cycle, state SLOW.
REQ-035 Paddle at 10, 5 rot_l pulses, frame_tick -> paddle_y 0, at_top 1, move_valid 1; repeat -> no move_valid.
REQ-036 2 rot_r per frame for 3 frames -> +8, +8, +8, state FAST; 4th frame -> +24.
REQ-037 FAST, 1 rot_l pulse, frame_tick -> -12 applied, state SLOW; next frame with 1 rot_l -> -4.
REQ-038 rot_l and rot_r coincident, plus a rot_r coincident with frame_tick -> coincident pair ignored; tick-cycle pulse moves +4 on the following tick.
REQ-039 20 rot_r pulses in one frame -> acc saturates at +15, paddle_y +60 (clamped to 416 if exceeded); rst pulsed mid-frame -> paddle_y 208 immediately, no carry-over.
